// File: rtl/vid_arb_pkg.sv
// Shared types and default sizing for the video RAM arbiter.
package vid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    RESP    = 2'd2
  } arb_state_e;

  localparam int ARB_ADDR_W  = 17;
  localparam int ARB_DATA_W  = 16;
  localparam int ARB_TO_W    = 8;
  localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/vid_arb_wait_cnt.sv
// Saturating counter of GFX-busy cycles seen by a pending host request.
module vid_arb_wait_cnt
  import vid_arb_pkg::*;
#(
  parameter int TO_W    = ARB_TO_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [TO_W-1:0] TO_VAL  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  logic [TO_W-1:0] cnt;

  // Holds at all-ones instead of wrapping so a stuck GFX port cannot
  // make a starved request look fresh again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign hit = (cnt == TO_VAL);

endmodule

// File: rtl/vid_ram_arbiter.sv
// Single-port video RAM sharing: GFX engine has absolute priority,
// Wishbone host uses idle cycles and is errored out if starved too long.
module vid_ram_arbiter
  import vid_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TO_W    = ARB_TO_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic              gfx_ram_cen_n_i,
  input  logic              gfx_ram_wen_n_i,
  input  logic [ADDR_W-1:0] gfx_ram_addr_i,
  input  logic [DATA_W-1:0] gfx_ram_din_i,
  output logic [DATA_W-1:0] gfx_ram_dout_o,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  input  logic [1:0]        wbs_sel_i,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              ram_cen_n_o,
  output logic              ram_wen_n_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              arb_conflict_o
);

  arb_state_e        state;
  logic              ack_q;
  logic              err_q;
  logic              conflict_q;
  logic [DATA_W-1:0] dat_q;

  logic req;
  logic gfx_act;
  logic wr_legal;
  logic deferred;
  logic host_go;
  logic wait_clr;
  logic wait_hit;
  logic unused_adr;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign gfx_act  = ~gfx_ram_cen_n_i;
  assign wr_legal = ~wbs_we_i | (wbs_sel_i == 2'b11);
  assign deferred = (state == IDLE) & req & wr_legal & gfx_act;
  assign host_go  = (state == IDLE) & req & wr_legal & ~gfx_act;
  assign wait_clr = ~deferred;

  // Byte address: bit 0 and bits above the RAM word range are ignored.
  assign unused_adr = ^{wbs_adr_i[31:ADDR_W+1], wbs_adr_i[0]};

  vid_arb_wait_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk   (mclk),
    .rst_n (puc_rst_n),
    .clr   (wait_clr),
    .inc   (deferred),
    .hit   (wait_hit)
  );

  // GFX owns the RAM whenever it asks; host only gets it from IDLE.
  always_comb begin
    ram_cen_n_o = 1'b1;
    ram_wen_n_o = 1'b1;
    ram_addr_o  = '0;
    ram_din_o   = '0;
    if (gfx_act) begin
      ram_cen_n_o = 1'b0;
      ram_wen_n_o = gfx_ram_wen_n_i;
      ram_addr_o  = gfx_ram_addr_i;
      ram_din_o   = gfx_ram_din_i;
    end else if (host_go) begin
      ram_cen_n_o = 1'b0;
      ram_wen_n_o = ~wbs_we_i;
      ram_addr_o  = wbs_adr_i[ADDR_W:1];
      ram_din_o   = wbs_dat_i;
    end
  end

  // Response flags are one-cycle pulses, so they default low every cycle.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state      <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
      dat_q      <= '0;
    end else begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (!wr_legal) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (gfx_act) begin
              conflict_q <= 1'b1;
              if (wait_hit) begin
                err_q <= 1'b1;
                state <= RESP;
              end
            end else if (wbs_we_i) begin
              ack_q <= 1'b1;
              state <= RESP;
            end else begin
              state <= RD_DATA;
            end
          end
        end
        RD_DATA: begin
          dat_q <= ram_dout_i;
          ack_q <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign gfx_ram_dout_o = ram_dout_i;
  assign wbs_dat_o      = dat_q;
  assign wbs_ack_o      = ack_q & wbs_cyc_i;
  assign wbs_err_o      = err_q & wbs_cyc_i;
  assign arb_conflict_o = conflict_q;

endmodule

// File: tb/tb_vid_ram_arbiter.sv
// Directed bench for vid_ram_arbiter with a small synchronous RAM model.
module tb_vid_ram_arbiter;

  logic        mclk;
  logic        puc_rst_n;
  logic        gfx_cen_n;
  logic        gfx_wen_n;
  logic [16:0] gfx_addr;
  logic [15:0] gfx_din;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [15:0] wdat;
  logic [1:0]  sel;
  logic [15:0] ram_dout;

  logic [15:0] gfx_dout;
  logic [15:0] dat;
  logic        ack;
  logic        err;
  logic        cen_n;
  logic        wen_n;
  logic [16:0] addr;
  logic [15:0] din;
  logic        conflict;

  logic [15:0] to_gfx_dout;
  logic [15:0] to_dat;
  logic        to_ack;
  logic        to_err;
  logic        to_cen_n;
  logic        to_wen_n;
  logic [16:0] to_addr;
  logic [15:0] to_din;
  logic        to_conflict;

  int checks;
  int errors;

  logic [15:0] mem [0:255];

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  vid_ram_arbiter dut (
    .mclk            (mclk),
    .puc_rst_n       (puc_rst_n),
    .gfx_ram_cen_n_i (gfx_cen_n),
    .gfx_ram_wen_n_i (gfx_wen_n),
    .gfx_ram_addr_i  (gfx_addr),
    .gfx_ram_din_i   (gfx_din),
    .gfx_ram_dout_o  (gfx_dout),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (wdat),
    .wbs_sel_i       (sel),
    .wbs_dat_o       (dat),
    .wbs_ack_o       (ack),
    .wbs_err_o       (err),
    .ram_cen_n_o     (cen_n),
    .ram_wen_n_o     (wen_n),
    .ram_addr_o      (addr),
    .ram_din_o       (din),
    .ram_dout_i      (ram_dout),
    .arb_conflict_o  (conflict)
  );

  // Second instance with a short watchdog for the starvation scenario.
  vid_ram_arbiter #(.TIMEOUT(4)) dut_to (
    .mclk            (mclk),
    .puc_rst_n       (puc_rst_n),
    .gfx_ram_cen_n_i (gfx_cen_n),
    .gfx_ram_wen_n_i (gfx_wen_n),
    .gfx_ram_addr_i  (gfx_addr),
    .gfx_ram_din_i   (gfx_din),
    .gfx_ram_dout_o  (to_gfx_dout),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (wdat),
    .wbs_sel_i       (sel),
    .wbs_dat_o       (to_dat),
    .wbs_ack_o       (to_ack),
    .wbs_err_o       (to_err),
    .ram_cen_n_o     (to_cen_n),
    .ram_wen_n_o     (to_wen_n),
    .ram_addr_o      (to_addr),
    .ram_din_o       (to_din),
    .ram_dout_i      (ram_dout),
    .arb_conflict_o  (to_conflict)
  );

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[8] = 16'hBEEF;
    ram_dout = 16'h0000;
  end

  always @(posedge mclk) begin
    if (!cen_n) begin
      if (!wen_n) mem[addr[7:0]] <= din;
      else        ram_dout <= mem[addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic host_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; wdat = 16'h0; sel = 2'b00;
  endtask

  task automatic host_req(input logic w, input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic test_reset();
    puc_rst_n = 1'b0;
    gfx_cen_n = 1'b1; gfx_wen_n = 1'b1; gfx_addr = '0; gfx_din = '0;
    host_idle();
    #22;
    checks++;
    if ({cen_n, wen_n, addr, din} !== {1'b1, 1'b1, 17'h0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL reset_ram: got cen=%b wen=%b addr=%h din=%h expected 1 1 0 0", cen_n, wen_n, addr, din);
    end
    checks++;
    if ({ack, err, conflict, dat} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL reset_resp: got ack=%b err=%b conf=%b dat=%h expected 0 0 0 0", ack, err, conflict, dat);
    end
    @(negedge mclk);
    puc_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    host_req(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    #1;
    checks++;
    if ({cen_n, wen_n, addr} !== {1'b0, 1'b1, 17'h8}) begin
      errors++;
      $display("[TB] FAIL read_issue: got cen=%b wen=%b addr=%h expected 0 1 8", cen_n, wen_n, addr);
    end
    tick();
    checks++;
    if ({ack, cen_n} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL read_rd_data: got ack=%b cen=%b expected 0 1", ack, cen_n);
    end
    tick();
    checks++;
    if ({ack, err, dat} !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("[TB] FAIL read_ack: got ack=%b err=%b dat=%h expected 1 0 beef", ack, err, dat);
    end
    host_idle();
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_ack_pulse: got %b expected 0", ack);
    end
  endtask

  task automatic test_write();
    host_req(1'b1, 32'h0000_000A, 16'h1234, 2'b11);
    #1;
    checks++;
    if ({cen_n, wen_n, addr, din} !== {1'b0, 1'b0, 17'h5, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL write_issue: got cen=%b wen=%b addr=%h din=%h expected 0 0 5 1234", cen_n, wen_n, addr, din);
    end
    tick();
    checks++;
    if ({ack, err} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL write_ack: got ack=%b err=%b expected 1 0", ack, err);
    end
    host_idle();
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_ack_pulse: got %b expected 0", ack);
    end
    host_req(1'b0, 32'h0000_000A, 16'h0, 2'b11);
    tick();
    tick();
    checks++;
    if ({ack, dat} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL write_readback: got ack=%b dat=%h expected 1 1234", ack, dat);
    end
    host_idle();
    tick();
  endtask

  task automatic test_gfx_priority();
    int conflicts;
    int ack_cycle;
    conflicts = 0;
    ack_cycle = 0;
    gfx_cen_n = 1'b0; gfx_wen_n = 1'b1; gfx_addr = 17'h12345; gfx_din = 16'h5A5A;
    host_req(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    for (int i = 1; i <= 12; i++) begin
      if (i <= 10) begin
        #1;
        checks++;
        if ({cen_n, wen_n, addr} !== {1'b0, 1'b1, 17'h12345}) begin
          errors++;
          $display("[TB] FAIL gfx_owns_ram c%0d: got cen=%b wen=%b addr=%h expected 0 1 12345", i, cen_n, wen_n, addr);
        end
      end
      tick();
      if (conflict) conflicts++;
      if (ack && ack_cycle == 0) ack_cycle = i;
      if (i == 10) gfx_cen_n = 1'b1;
    end
    checks++;
    if (conflicts !== 10) begin
      errors++;
      $display("[TB] FAIL gfx_conflicts: got %0d expected 10", conflicts);
    end
    checks++;
    if (ack_cycle !== 12) begin
      errors++;
      $display("[TB] FAIL gfx_ack_cycle: got %0d expected 12", ack_cycle);
    end
    checks++;
    if (dat !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL gfx_read_data: got %h expected beef", dat);
    end
    host_idle();
    tick();
  endtask

  task automatic test_timeout();
    int conflicts;
    int err_cycle;
    int err_cnt;
    int ack_cnt;
    int main_err;
    conflicts = 0; err_cycle = 0; err_cnt = 0; ack_cnt = 0; main_err = 0;
    gfx_cen_n = 1'b0; gfx_wen_n = 1'b1; gfx_addr = 17'h00077; gfx_din = 16'h0;
    host_req(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    for (int i = 1; i <= 6; i++) begin
      #1;
      checks++;
      if ({to_cen_n, to_addr} !== {1'b0, 17'h00077}) begin
        errors++;
        $display("[TB] FAIL timeout_gfx_owns c%0d: got cen=%b addr=%h expected 0 77", i, to_cen_n, to_addr);
      end
      tick();
      if (to_conflict) conflicts++;
      if (to_ack) ack_cnt++;
      if (to_err) err_cnt++;
      if (to_err && err_cycle == 0) err_cycle = i;
      if (err) main_err++;
      if (i == 5) host_idle();
    end
    checks++;
    if (err_cycle !== 5) begin
      errors++;
      $display("[TB] FAIL timeout_err_cycle: got %0d expected 5", err_cycle);
    end
    checks++;
    if ({err_cnt, ack_cnt} !== {32'd1, 32'd0}) begin
      errors++;
      $display("[TB] FAIL timeout_resp_count: got err=%0d ack=%0d expected 1 0", err_cnt, ack_cnt);
    end
    checks++;
    if (conflicts !== 5) begin
      errors++;
      $display("[TB] FAIL timeout_conflicts: got %0d expected 5", conflicts);
    end
    checks++;
    if (main_err !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_default_inst: got %0d errors expected 0", main_err);
    end
    gfx_cen_n = 1'b1;
    #1;
    checks++;
    if (to_cen_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_no_access: got cen=%b expected 1", to_cen_n);
    end
    tick();
  endtask

  task automatic test_partial_write_and_cyc_drop();
    host_req(1'b1, 32'h0000_0006, 16'hDEAD, 2'b01);
    #1;
    checks++;
    if ({cen_n, wen_n} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL partial_no_access: got cen=%b wen=%b expected 1 1", cen_n, wen_n);
    end
    tick();
    checks++;
    if ({err, ack, wen_n} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL partial_err: got err=%b ack=%b wen=%b expected 1 0 1", err, ack, wen_n);
    end
    host_idle();
    tick();
    checks++;
    if ({err, mem[3]} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL partial_after: got err=%b mem3=%h expected 0 0", err, mem[3]);
    end
    host_req(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    tick();
    host_idle();
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cyc_drop_ack: got %b expected 0", ack);
    end
    tick();
    host_req(1'b0, 32'h0000_000A, 16'h0, 2'b11);
    #1;
    checks++;
    if ({cen_n, addr} !== {1'b0, 17'h5}) begin
      errors++;
      $display("[TB] FAIL cyc_drop_idle: got cen=%b addr=%h expected 0 5", cen_n, addr);
    end
    tick();
    tick();
    checks++;
    if ({ack, dat} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL cyc_drop_next_read: got ack=%b dat=%h expected 1 1234", ack, dat);
    end
    host_idle();
    tick();
  endtask

  task automatic test_reset_mid_op();
    host_req(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    tick();
    #2;
    puc_rst_n = 1'b0;
    #1;
    checks++;
    if ({dat, ack, err, conflict} !== {16'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rst_mid_resp: got dat=%h ack=%b err=%b conf=%b expected 0 0 0 0", dat, ack, err, conflict);
    end
    checks++;
    if ({cen_n, addr} !== {1'b0, 17'h8}) begin
      errors++;
      $display("[TB] FAIL rst_mid_state_idle: got cen=%b addr=%h expected 0 8", cen_n, addr);
    end
    host_idle();
    #1;
    checks++;
    if ({cen_n, wen_n, addr, din} !== {1'b1, 1'b1, 17'h0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL rst_mid_ram: got cen=%b wen=%b addr=%h din=%h expected 1 1 0 0", cen_n, wen_n, addr, din);
    end
    @(negedge mclk);
    puc_rst_n = 1'b1;
    tick();
    host_req(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_after_early_ack: got %b expected 0", ack);
    end
    tick();
    checks++;
    if ({ack, dat} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("[TB] FAIL rst_after_read: got ack=%b dat=%h expected 1 beef", ack, dat);
    end
    host_idle();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_write();
    test_gfx_priority();
    test_timeout();
    test_partial_write_and_cyc_drop();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
